// File: rtl/enemy_patrol_unit.sv
// Single patrolling enemy: moves once per frame tick, checks hero contact and attack hits, respawns after a delay.
// Overlays its box on the pixel stream with 1-cycle latency on the whole timing/rgb bus.
module enemy_patrol_unit #(
    parameter int          ENEMY_W        = 32,
    parameter int          ENEMY_H        = 32,
    parameter int          HERO_W         = 32,
    parameter int          HERO_H         = 32,
    parameter int          ATK_W          = 16,
    parameter int          ATK_H          = 16,
    parameter int          START_X        = 100,
    parameter int          START_Y        = 200,
    parameter int          X_MIN          = 64,
    parameter int          X_MAX          = 600,
    parameter int          STEP           = 2,
    parameter logic [11:0] COLOR          = 12'hF00,
    parameter int          RESPAWN_FRAMES = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] hero_x_pos,
    input  logic [11:0] hero_y_pos,
    input  logic [11:0] hero_attack_x_pos,
    input  logic [11:0] hero_attack_y_pos,
    input  logic        attack_active,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        alive,
    output logic        player_collision,
    output logic        eliminated,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [12:0] EW    = 13'(ENEMY_W);
    localparam logic [12:0] EH    = 13'(ENEMY_H);
    localparam logic [12:0] HW    = 13'(HERO_W);
    localparam logic [12:0] HH    = 13'(HERO_H);
    localparam logic [12:0] AW    = 13'(ATK_W);
    localparam logic [12:0] AH    = 13'(ATK_H);
    localparam logic [12:0] STP13 = 13'(STEP);
    localparam logic [12:0] XMIN13 = 13'(X_MIN);
    localparam logic [12:0] XMAX13 = 13'(X_MAX);
    localparam logic [11:0] STP12 = 12'(STEP);
    localparam logic [15:0] RESPAWN_CNT = 16'(RESPAWN_FRAMES);
    localparam bit          NEVER_RESPAWN = (RESPAWN_FRAMES == 0);

    typedef enum logic [1:0] {MOVE_R, MOVE_L, DEAD} state_t;

    state_t      state, state_nxt;
    logic [11:0] x_nxt;
    logic        alive_nxt, coll_nxt, elim_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        vsync_prev;
    logic        tick;
    logic        hero_ov, atk_ov, in_box;
    logic [12:0] ex, ey, hx, hy, ax, ay, hc, vc;

    assign tick = vsync_in & ~vsync_prev;

    // All box arithmetic is 13-bit so right/bottom edges near 4095 never wrap.
    assign ex = {1'b0, x_pos};
    assign ey = {1'b0, y_pos};
    assign hx = {1'b0, hero_x_pos};
    assign hy = {1'b0, hero_y_pos};
    assign ax = {1'b0, hero_attack_x_pos};
    assign ay = {1'b0, hero_attack_y_pos};
    assign hc = {2'b0, hcount_in};
    assign vc = {2'b0, vcount_in};

    assign hero_ov = (ex < hx + HW) && (hx < ex + EW) && (ey < hy + HH) && (hy < ey + EH);
    assign atk_ov  = (ex < ax + AW) && (ax < ex + EW) && (ey < ay + AH) && (ay < ey + EH);
    assign in_box  = alive && !(vblnk_in || hblnk_in) &&
                     (ex <= hc) && (hc < ex + EW) && (ey <= vc) && (vc < ey + EH);

    always_comb begin
        state_nxt = state;
        x_nxt     = x_pos;
        alive_nxt = alive;
        coll_nxt  = player_collision;
        elim_nxt  = 1'b0;
        cnt_nxt   = cnt;
        if (tick) begin
            case (state)
                MOVE_R, MOVE_L: begin
                    // Kill is judged on the pre-move position and takes priority over contact.
                    if (attack_active && atk_ov) begin
                        state_nxt = DEAD;
                        alive_nxt = 1'b0;
                        elim_nxt  = 1'b1;
                        coll_nxt  = 1'b0;
                        cnt_nxt   = RESPAWN_CNT;
                    end else begin
                        coll_nxt = hero_ov;
                        if (state == MOVE_R) begin
                            if (ex + STP13 >= XMAX13) begin
                                x_nxt     = 12'(X_MAX);
                                state_nxt = MOVE_L;
                            end else begin
                                x_nxt = x_pos + STP12;
                            end
                        end else begin
                            if (ex <= XMIN13 + STP13) begin
                                x_nxt     = 12'(X_MIN);
                                state_nxt = MOVE_R;
                            end else begin
                                x_nxt = x_pos - STP12;
                            end
                        end
                    end
                end
                DEAD: begin
                    coll_nxt = 1'b0;
                    if (!NEVER_RESPAWN) begin
                        cnt_nxt = cnt - 16'd1;
                        if (cnt_nxt == 16'd0) begin
                            x_nxt     = 12'(START_X);
                            alive_nxt = 1'b1;
                            state_nxt = MOVE_R;
                        end
                    end
                end
                default: state_nxt = MOVE_R;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= MOVE_R;
            x_pos            <= 12'(START_X);
            y_pos            <= 12'(START_Y);
            alive            <= 1'b1;
            player_collision <= 1'b0;
            eliminated       <= 1'b0;
            cnt              <= 16'd0;
            vsync_prev       <= 1'b0;
        end else begin
            state            <= state_nxt;
            x_pos            <= x_nxt;
            alive            <= alive_nxt;
            player_collision <= coll_nxt;
            eliminated       <= elim_nxt;
            cnt              <= cnt_nxt;
            vsync_prev       <= vsync_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcount_out <= 11'd0;
            hcount_out <= 11'd0;
            vsync_out  <= 1'b0;
            hsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            vcount_out <= vcount_in;
            hcount_out <= hcount_in;
            vsync_out  <= vsync_in;
            hsync_out  <= hsync_in;
            vblnk_out  <= vblnk_in;
            hblnk_out  <= hblnk_in;
            rgb_out    <= in_box ? COLOR : rgb_in;
        end
    end

endmodule

// File: tb/tb_enemy_patrol_unit.sv
// Directed bench: dut_a uses default geometry with a 3-tick respawn, dut_b a narrow patrol for turn-around.
module tb_enemy_patrol_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hero_x_pos, hero_y_pos, hero_attack_x_pos, hero_attack_y_pos;
    logic        attack_active;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic [11:0] rgb_in;

    logic [11:0] a_x, a_y, a_rgb;
    logic        a_alive, a_coll, a_elim;
    logic [10:0] a_vc, a_hc;
    logic        a_vs, a_hs, a_vb, a_hb;

    logic [11:0] b_x, b_y, b_rgb;
    logic        b_alive, b_coll, b_elim;
    logic [10:0] b_vc, b_hc;
    logic        b_vs, b_hs, b_vb, b_hb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    enemy_patrol_unit #(.RESPAWN_FRAMES(3)) dut_a (
        .clk(clk), .rst(rst),
        .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
        .hero_attack_x_pos(hero_attack_x_pos), .hero_attack_y_pos(hero_attack_y_pos),
        .attack_active(attack_active),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in),
        .x_pos(a_x), .y_pos(a_y), .alive(a_alive), .player_collision(a_coll), .eliminated(a_elim),
        .vcount_out(a_vc), .hcount_out(a_hc), .vsync_out(a_vs), .hsync_out(a_hs),
        .vblnk_out(a_vb), .hblnk_out(a_hb), .rgb_out(a_rgb)
    );

    enemy_patrol_unit #(.X_MAX(110), .STEP(4)) dut_b (
        .clk(clk), .rst(rst),
        .hero_x_pos(hero_x_pos), .hero_y_pos(hero_y_pos),
        .hero_attack_x_pos(hero_attack_x_pos), .hero_attack_y_pos(hero_attack_y_pos),
        .attack_active(attack_active),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .hsync_in(hsync_in), .vblnk_in(vblnk_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in),
        .x_pos(b_x), .y_pos(b_y), .alive(b_alive), .player_collision(b_coll), .eliminated(b_elim),
        .vcount_out(b_vc), .hcount_out(b_hc), .vsync_out(b_vs), .hsync_out(b_hs),
        .vblnk_out(b_vb), .hblnk_out(b_hb), .rgb_out(b_rgb)
    );

    task automatic do_reset();
        rst = 1'b1;
        hero_x_pos = 12'd0; hero_y_pos = 12'd0;
        hero_attack_x_pos = 12'd0; hero_attack_y_pos = 12'd0;
        attack_active = 1'b0;
        vcount_in = 11'd0; hcount_in = 11'd0;
        vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
        rgb_in = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle vsync pulse; returns at the negedge after the tick edge.
    task automatic frame_tick();
        @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (a_x !== 12'd100) begin fails++; $display("FAIL reset_x got %0d want 100", a_x); end
        tests++; if (a_y !== 12'd200) begin fails++; $display("FAIL reset_y got %0d want 200", a_y); end
        tests++; if (a_alive !== 1'b1 || a_coll !== 1'b0 || a_elim !== 1'b0) begin
            fails++; $display("FAIL reset_flags got alive=%b coll=%b elim=%b want 1 0 0", a_alive, a_coll, a_elim);
        end
        tests++; if (a_rgb !== 12'd0 || a_hc !== 11'd0 || a_vs !== 1'b0) begin
            fails++; $display("FAIL reset_bus got rgb=%h hc=%0d vs=%b want 0 0 0", a_rgb, a_hc, a_vs);
        end
    endtask

    task automatic test_patrol();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            frame_tick();
            tests++; if (a_x !== 12'(100 + 2 * i)) begin
                fails++; $display("FAIL patrol_x tick %0d got %0d want %0d", i, a_x, 100 + 2 * i);
            end
            tests++; if (a_coll !== 1'b0 || a_alive !== 1'b1) begin
                fails++; $display("FAIL patrol_flags tick %0d got coll=%b alive=%b want 0 1", i, a_coll, a_alive);
            end
        end
    endtask

    task automatic test_turnaround();
        logic [11:0] exp_x [5];
        exp_x[0] = 12'd104; exp_x[1] = 12'd108; exp_x[2] = 12'd110; exp_x[3] = 12'd106; exp_x[4] = 12'd102;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            frame_tick();
            tests++; if (b_x !== exp_x[i]) begin
                fails++; $display("FAIL turn_x tick %0d got %0d want %0d", i + 1, b_x, exp_x[i]);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        hero_x_pos = 12'd120; hero_y_pos = 12'd210;
        frame_tick();
        tests++; if (a_coll !== 1'b1) begin fails++; $display("FAIL coll_overlap got %b want 1", a_coll); end
        hero_x_pos = 12'd0; hero_y_pos = 12'd0;
        repeat (4) @(negedge clk);
        tests++; if (a_coll !== 1'b1) begin fails++; $display("FAIL coll_held got %b want 1", a_coll); end
        // Enemy now at 102, so hero at 134 touches its right edge exactly.
        hero_x_pos = 12'd134; hero_y_pos = 12'd210;
        frame_tick();
        tests++; if (a_coll !== 1'b0) begin fails++; $display("FAIL coll_edge got %b want 0", a_coll); end
        tests++; if (a_x !== 12'd104) begin fails++; $display("FAIL coll_x got %0d want 104", a_x); end
    endtask

    task automatic test_kill_respawn();
        do_reset();
        hero_x_pos = 12'd120; hero_y_pos = 12'd210;
        hero_attack_x_pos = 12'd110; hero_attack_y_pos = 12'd210;
        attack_active = 1'b1;
        frame_tick();
        tests++; if (a_elim !== 1'b1 || a_alive !== 1'b0 || a_coll !== 1'b0) begin
            fails++; $display("FAIL kill got elim=%b alive=%b coll=%b want 1 0 0", a_elim, a_alive, a_coll);
        end
        tests++; if (a_x !== 12'd100) begin fails++; $display("FAIL kill_x got %0d want 100", a_x); end
        attack_active = 1'b0;
        @(negedge clk);
        tests++; if (a_elim !== 1'b0) begin fails++; $display("FAIL elim_pulse got %b want 0", a_elim); end
        hcount_in = 11'd100; vcount_in = 11'd200; rgb_in = 12'h0F0;
        @(negedge clk);
        tests++; if (a_rgb !== 12'h0F0) begin fails++; $display("FAIL dead_render got %h want 0f0", a_rgb); end
        for (int i = 1; i <= 3; i++) begin
            frame_tick();
            tests++; if (a_alive !== (i == 3) || a_coll !== 1'b0) begin
                fails++; $display("FAIL respawn tick %0d got alive=%b coll=%b want %0d 0", i, a_alive, a_coll, (i == 3));
            end
        end
        tests++; if (a_x !== 12'd100) begin fails++; $display("FAIL respawn_x got %0d want 100", a_x); end
        hero_x_pos = 12'd0; hero_y_pos = 12'd0;
        frame_tick();
        tests++; if (a_x !== 12'd102) begin fails++; $display("FAIL respawn_move got %0d want 102", a_x); end
    endtask

    task automatic test_render();
        do_reset();
        @(negedge clk);
        hcount_in = 11'd100; vcount_in = 11'd200; rgb_in = 12'h0F0; hsync_in = 1'b1;
        @(negedge clk);
        tests++; if (a_rgb !== 12'hF00 || a_hc !== 11'd100 || a_vc !== 11'd200 || a_hs !== 1'b1) begin
            fails++; $display("FAIL render_in got rgb=%h hc=%0d vc=%0d hs=%b want f00 100 200 1", a_rgb, a_hc, a_vc, a_hs);
        end
        hcount_in = 11'd131;
        @(negedge clk);
        tests++; if (a_rgb !== 12'hF00) begin fails++; $display("FAIL render_last_col got %h want f00", a_rgb); end
        hcount_in = 11'd132;
        @(negedge clk);
        tests++; if (a_rgb !== 12'h0F0) begin fails++; $display("FAIL render_right_edge got %h want 0f0", a_rgb); end
        hcount_in = 11'd100; vcount_in = 11'd199;
        @(negedge clk);
        tests++; if (a_rgb !== 12'h0F0) begin fails++; $display("FAIL render_above got %h want 0f0", a_rgb); end
        vcount_in = 11'd200; hblnk_in = 1'b1;
        @(negedge clk);
        tests++; if (a_rgb !== 12'h0F0 || a_hb !== 1'b1) begin
            fails++; $display("FAIL render_hblnk got rgb=%h hb=%b want 0f0 1", a_rgb, a_hb);
        end
        hblnk_in = 1'b0; vblnk_in = 1'b1;
        @(negedge clk);
        tests++; if (a_rgb !== 12'h0F0 || a_vb !== 1'b1) begin
            fails++; $display("FAIL render_vblnk got rgb=%h vb=%b want 0f0 1", a_rgb, a_vb);
        end
        vblnk_in = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        hero_attack_x_pos = 12'd110; hero_attack_y_pos = 12'd210;
        attack_active = 1'b1;
        frame_tick();
        attack_active = 1'b0;
        hcount_in = 11'd55; vcount_in = 11'd7; rgb_in = 12'h123; hsync_in = 1'b1;
        @(negedge clk);
        tests++; if (a_alive !== 1'b0 || a_hc !== 11'd55 || a_rgb !== 12'h123) begin
            fails++; $display("FAIL pre_reset got alive=%b hc=%0d rgb=%h want 0 55 123", a_alive, a_hc, a_rgb);
        end
        #2 rst = 1'b1;
        #1;
        tests++; if (a_alive !== 1'b1 || a_x !== 12'd100 || a_hc !== 11'd0 || a_rgb !== 12'd0 || a_hs !== 1'b0) begin
            fails++; $display("FAIL async_reset got alive=%b x=%0d hc=%0d rgb=%h hs=%b want 1 100 0 000 0",
                              a_alive, a_x, a_hc, a_rgb, a_hs);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (a_hc !== 11'd55 || a_rgb !== 12'h123) begin
            fails++; $display("FAIL bus_resume got hc=%0d rgb=%h want 55 123", a_hc, a_rgb);
        end
        frame_tick();
        tests++; if (a_x !== 12'd102 || a_alive !== 1'b1) begin
            fails++; $display("FAIL post_reset_move got x=%0d alive=%b want 102 1", a_x, a_alive);
        end
    endtask

    initial begin
        test_reset();
        test_patrol();
        test_turnaround();
        test_collision();
        test_kill_respawn();
        test_render();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enemy_patrol_unit.md
Name: enemy_patrol_unit

Overview:
- Parametrised successor to the single-enemy overlay stage in the VGA render chain: one enemy that patrols horizontally, detects hero contact and attack hits, and respawns after a delay.
- Sits in series in the pixel pipeline: takes the timing bus plus rgb, returns a 1-cycle-delayed bus with the enemy sprite box overlaid.
- Several instances with different parameters are chained to populate a level.

Parameters:
- ENEMY_W, 32, enemy box width in pixels
- ENEMY_H, 32, enemy box height in pixels
- HERO_W, 32, hero box width (hero_y box height uses HERO_H)
- HERO_H, 32, hero box height
- ATK_W, 16, attack box width
- ATK_H, 16, attack box height
- START_X, 100, spawn x (top-left)
- START_Y, 200, spawn/patrol y (top-left)
- X_MIN, 64, left patrol bound
- X_MAX, 600, right patrol bound; X_MIN <= START_X <= X_MAX required
- STEP, 2, pixels moved per frame tick (1..15)
- COLOR, 12'hF00, enemy fill colour
- RESPAWN_FRAMES, 120, frame ticks spent dead; 0 = never respawn

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hero_x_pos  in  12  hero top-left x
- hero_y_pos  in  12  hero top-left y
- hero_attack_x_pos  in  12  attack box top-left x
- hero_attack_y_pos  in  12  attack box top-left y
- attack_active  in  1  attack box valid this frame
- vcount_in/hcount_in  in  11 each  pixel counters
- vsync_in/hsync_in/vblnk_in/hblnk_in  in  1 each  timing
- rgb_in  in  12  upstream pixel
- x_pos/y_pos  out  12 each  current enemy top-left
- alive  out  1  enemy active
- player_collision  out  1  level: hero overlapping live enemy at last tick
- eliminated  out  1  one-cycle pulse on kill
- vcount_out/hcount_out/vsync_out/hsync_out/vblnk_out/hblnk_out/rgb_out  out  matching widths  delayed bus

Behaviour:
- Reset (async, rst=1): x_pos=START_X, y_pos=START_Y, state=MOVE_R, alive=1, player_collision=0, eliminated=0, respawn counter=0, all bus outputs 0, vsync edge register 0.
- Frame tick: single-cycle pulse on rising edge of vsync_in (vsync_in=1 and registered previous=0). All game logic updates only on tick cycles.
- Overlap(A,B): A.x < B.x+B.w AND B.x < A.x+A.w AND same for y; sums computed 13-bit, no wrap; touching edges do not overlap.
- States: MOVE_R, MOVE_L, DEAD.
- MOVE_R on tick: if x_pos+STEP >= X_MAX then x_pos=X_MAX, ->MOVE_L; else x_pos+=STEP.
- MOVE_L on tick: if x_pos <= X_MIN+STEP then x_pos=X_MIN, ->MOVE_R; else x_pos-=STEP.
- Hit check on tick in MOVE_R/MOVE_L uses pre-move position: attack_active and Overlap(enemy, attack box) -> DEAD, alive=0, eliminated=1 for that cycle only, counter=RESPAWN_FRAMES, position not updated, player_collision=0.
- Otherwise player_collision = Overlap(enemy, hero box); held until next tick.
- Simultaneous hit and hero contact: kill wins; player_collision=0.
- DEAD on tick: if RESPAWN_FRAMES=0 stay DEAD forever; else decrement counter; on the tick where it reaches 0 -> x_pos=START_X, alive=1, ->MOVE_R. player_collision=0 throughout DEAD.
- Render (every cycle, 1-cycle latency): all timing outputs = inputs registered once. rgb_out = COLOR if alive and not (vblnk_in or hblnk_in) and x_pos <= hcount_in < x_pos+ENEMY_W and y_pos <= vcount_in < y_pos+ENEMY_H; else rgb_in. Comparison uses x_pos/y_pos as registered at that cycle (mid-frame moves cannot occur; updates happen at vsync).
- Reset mid-frame: bus outputs go 0 immediately; resume on next clock after release.

Test Plan:
- Reset, run 10 frames, no hero nearby (hero at 0,0) -> x_pos=100,102,...,120 on successive ticks; player_collision=0; alive=1.
- X_MAX=110, START_X=100, STEP=4 -> x: 104,108,110(turn),106,102 over 5 ticks.
- Hero at (120,210) when enemy at x=100 -> player_collision=1 after tick; hero at (132,210) -> 0 (edge touch).
- attack_active=1, attack at (110,210) while hero also overlaps -> eliminated high exactly 1 cycle, alive=0, player_collision=0; RESPAWN_FRAMES=3 -> alive=1, x_pos=100 on 3rd subsequent tick.
- Pixel (hcount=100,vcount=200) with enemy at (100,200), rgb_in=12'h0F0 -> rgb_out=12'hF00 one cycle later; hcount=132 -> 12'h0F0; same pixel with hblnk_in=1 -> rgb_in passed.
- Assert rst mid-frame during DEAD -> outputs reset asynchronously, alive=1, x_pos=100, state MOVE_R.
